decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage of the 5-stage RV32I pipeline; consumes fetch outputs (instr_d, pc_d, pc_plus4_d).
//  Decodes the instruction and reads the register file, with write-back writes from W stage.
//  Generates the sign-extended immediate and drives the ID/EX pipeline register into execute.
//  Execute's branch-taken signal (pc_src_e) is looped back here as flush_e to squash the wrong-path op.
// PARAMETERS
//  XLEN      32  datapath width
//  NUM_REGS  32  architectural registers; x0 hardwired to 0
// PORTS
//  clk            in   1     clock, all state updates on posedge
//  rst            in   1     synchronous, active-high reset
//  instr_d        in   32    instruction from fetch
//  pc_d           in   32    PC of instr_d
//  pc_plus4_d     in   32    pc_d+4
//  stall_e        in   1     hold ID/EX register (hazard unit)
//  flush_e        in   1     load bubble into ID/EX (branch taken / load-use)
//  reg_write_w    in   1     write-back enable
//  rd_w           in   5     write-back register
//  result_w       in   32    write-back data
//  reg_write_e    out  1     E-stage control: write rd
//  result_src_e   out  2     00 ALU, 01 mem, 10 pc+4
//  mem_write_e    out  1     store
//  jump_e         out  1     jal
//  branch_e       out  1     beq
//  alu_src_e      out  1     0 rd2, 1 imm
//  alu_ctrl_e     out  3     000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_e      out  1     unsupported opcode/funct decoded
//  rd1_e, rd2_e   out  32    register operands
//  imm_ext_e      out  32    sign-extended immediate
//  rs1_e, rs2_e   out  5     source indices (forwarding)
//  rd_e           out  5     destination index
//  pc_e           out  32    PC
//  pc_plus4_e     out  32    PC+4
// BEHAVIOUR
//  - Supported: lw(0000011) sw(0100011) R-type(0110011: add,sub,and,or,slt) addi(0010011, f3=000) beq(1100011) jal(1101111).
//  - Any other opcode/funct combination: all control bits 0 (NOP), illegal_e=1 in E.
//  - imm: I=instr[31:20]; S={[31:25],[11:7]}; B={[31],[7],[30:25],[11:8],0}; J={[31],[19:12],[20],[30:21],0}; all sign-extended from instr[31].
//  - sub selected when opcode=R, funct3=000, funct7[5]=1; addi never subtracts.
//  - Register file: combinational read, posedge write when reg_write_w && rd_w!=0.
//  - Write to x0 ignored; x0 always reads 0.
//  - Same-cycle write/read of same reg (rd_w!=0): read returns result_w (internal bypass); no extra latency.
//  - ID/EX register, latency 1 cycle D->E. Per-posedge priority: rst > flush_e > stall_e > load.
//    rst: every output 0 and all 31 registers cleared to 0.
//    flush_e: every E output 0 (bubble), incl. illegal_e. flush_e wins over stall_e.
//    stall_e: all E outputs hold; regfile write still happens.
//    load: capture decoded values of instr_d.
//  - Reset asserted mid-stream clears state on that edge; first valid E output appears 1 cycle after rst drops.
//  - instr_d=32'h0000_0013 (addi x0,x0,0) decodes as legal NOP with reg_write_e=1, rd_e=0 (harmless).
// STRUCTURE
//  - cpu_pkg: opcode constants, alu_ctrl_t, imm_src_t (I,S,B,J), result_src_t, XLEN.
//  - register_file sub-module: 2R/1W with reset and write bypass.
//  - Control decode, imm gen and ID/EX register stay in this module.
// TESTING
//  1 rst=1 two cycles -> all outputs 0; after release, any x1..x31 read returns 0.
//  2 Write x5=32'hDEAD_BEEF via W port, then instr_d=add x6,x5,x0 (32'h00028333)
//    -> next cycle rd1_e=DEADBEEF, alu_ctrl_e=000, reg_write_e=1, rd_e=6.
//  3 Same cycle: W writes x7=0x1234 while instr_d=addi x8,x7,-1 (32'hFFF38413)
//    -> rd1_e=0x1234, imm_ext_e=FFFFFFFF, alu_src_e=1.
//  4 beq x1,x2,-8 (32'hFE208CE3) -> branch_e=1, imm_ext_e=FFFFFFF8; jal x1,+2048 (32'h001000EF) -> jump_e=1, result_src_e=10, imm_ext_e=00000800.
//  5 stall_e=1 two cycles with changing instr_d -> E outputs frozen; stall_e+flush_e together -> bubble.
//  6 instr_d=32'hFFFFFFFF -> illegal_e=1, reg_write_e=0, mem_write_e=0; write to x0 then read -> 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I decode definitions.
//   XLEN / NUM_REGS   datapath width and architectural register count
//   OP_*              supported major opcodes
//   alu_ctrl_t        ALU operation select driven into execute
//   imm_src_t         immediate format selector (I, S, B, J)
//   result_src_t      write-back mux select
//   ctrl_t / id_ex_t  decoded control bundle and the full ID/EX register image
//   imm_gen()         sign-extended immediate for a given format
package cpu_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
    ALU_OR  = 3'b011, ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    alu_ctrl_t   alu_ctrl;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } id_ex_t;

  function automatic logic [XLEN-1:0] imm_gen(logic [31:0] instr, imm_src_t src);
    logic [XLEN-1:0] imm;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch inputs, hazard controls, write-back port and the
// E-stage outputs of the decode stage.
//   master: drives fetch/hazard/write-back, observes E outputs (upstream/bench)
//   slave:  the decode stage itself
interface decode_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] instr_d, pc_d, pc_plus4_d;
  logic            stall_e, flush_e;
  logic            reg_write_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;

  logic            reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, illegal_e;
  logic [1:0]      result_src_e;
  logic [2:0]      alu_ctrl_e;
  logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;

  modport master (
    output instr_d, pc_d, pc_plus4_d, stall_e, flush_e, reg_write_w, rd_w, result_w,
    input  reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e,
           alu_ctrl_e, illegal_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e,
           pc_e, pc_plus4_e
  );

  modport slave (
    input  instr_d, pc_d, pc_plus4_d, stall_e, flush_e, reg_write_w, rd_w, result_w,
    output reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e,
           alu_ctrl_e, illegal_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e,
           pc_e, pc_plus4_e
  );
endinterface

// File: rtl/decode_stage_register_file.sv
// register_file: 2-read / 1-write architectural register file.
//   clk, rst      clock, synchronous active-high reset (clears x1..x31)
//   ra1, ra2      read addresses, combinational data on rd1, rd2
//   we, wa, wd    posedge write port; writes to x0 are dropped
// A read of the register being written in the same cycle returns wd.
module register_file
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  // x0 has no storage
  logic [NUM_REGS-1:1][XLEN-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // Reading the next-state image gives the write bypass for free
  assign rd1 = (ra1 == '0) ? '0 : regs_d[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_d[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage (lw, sw, add/sub/and/or/slt, addi, beq, jal).
//   clk, rst   clock, synchronous active-high reset
//   bus        decode_stage_if.slave: fetch inputs, stall/flush, W-stage write
//              port, and the ID/EX register outputs (*_e)
// Unsupported encodings decode to an all-zero control word with illegal set.
// ID/EX update priority per edge: rst > flush_e > stall_e > load.
module decode_stage
  import cpu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  logic [31:0]     instr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  ctrl_t           ctrl;
  imm_src_t        imm_src;
  logic            legal;
  id_ex_t          id_ex_q, id_ex_d;

  assign instr  = bus.instr_d;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .we  (bus.reg_write_w),
    .wa  (bus.rd_w),
    .wd  (bus.result_w),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    legal   = 1'b0;
    case (opcode)
      OP_LW: begin
        legal = (funct3 == 3'b010);
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        legal = (funct3 == 3'b010);
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_R: begin
        legal = 1'b1;
        ctrl.reg_write = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: ctrl.alu_ctrl = ALU_ADD;
          10'b0100000_000: ctrl.alu_ctrl = ALU_SUB;
          10'b0000000_111: ctrl.alu_ctrl = ALU_AND;
          10'b0000000_110: ctrl.alu_ctrl = ALU_OR;
          10'b0000000_010: ctrl.alu_ctrl = ALU_SLT;
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        // only funct3=000; shifts/slti etc. are outside the supported set
        legal = (funct3 == 3'b000);
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        legal = (funct3 == 3'b000);
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;  // equality via zero flag of rs1-rs2
        imm_src       = IMM_B;
      end
      OP_JAL: begin
        legal = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
  end

  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.flush_e) begin
      id_ex_d = '0;
    end else if (!bus.stall_e) begin
      id_ex_d.ctrl     = ctrl;
      id_ex_d.rd1      = rf_rd1;
      id_ex_d.rd2      = rf_rd2;
      id_ex_d.imm_ext  = imm_gen(instr, imm_src);
      id_ex_d.rs1      = rs1;
      id_ex_d.rs2      = rs2;
      id_ex_d.rd       = rd;
      id_ex_d.pc       = bus.pc_d;
      id_ex_d.pc_plus4 = bus.pc_plus4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign bus.reg_write_e  = id_ex_q.ctrl.reg_write;
  assign bus.result_src_e = id_ex_q.ctrl.result_src;
  assign bus.mem_write_e  = id_ex_q.ctrl.mem_write;
  assign bus.jump_e       = id_ex_q.ctrl.jump;
  assign bus.branch_e     = id_ex_q.ctrl.branch;
  assign bus.alu_src_e    = id_ex_q.ctrl.alu_src;
  assign bus.alu_ctrl_e   = id_ex_q.ctrl.alu_ctrl;
  assign bus.illegal_e    = id_ex_q.ctrl.illegal;
  assign bus.rd1_e        = id_ex_q.rd1;
  assign bus.rd2_e        = id_ex_q.rd2;
  assign bus.imm_ext_e    = id_ex_q.imm_ext;
  assign bus.rs1_e        = id_ex_q.rs1;
  assign bus.rs2_e        = id_ex_q.rs2;
  assign bus.rd_e         = id_ex_q.rd;
  assign bus.pc_e         = id_ex_q.pc;
  assign bus.pc_plus4_e   = id_ex_q.pc_plus4;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table of instructions with hand-derived control words and
// immediates, plus hand sequences for bypass, x0, stall/flush and reset.
// Expected E-stage images are queued when an instruction is driven and popped
// one cycle later when the ID/EX register presents it.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  // {reg_write, result_src[1:0], mem_write, jump, branch, alu_src, alu_ctrl[2:0], illegal}
  typedef struct packed {
    logic [10:0] ctrl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4;
  } obs_t;

  typedef struct {
    string name;
    obs_t  o;
    bit    imm_chk;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [10:0] ctrl;
    logic [31:0] imm;
    bit          imm_chk;
  } vec_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] regm[32];
  obs_t        act;
  vec_t        tbl[15];

  assign act = {bus.reg_write_e, bus.result_src_e, bus.mem_write_e, bus.jump_e,
                bus.branch_e, bus.alu_src_e, bus.alu_ctrl_e, bus.illegal_e,
                bus.rd1_e, bus.rd2_e, bus.imm_ext_e, bus.rs1_e, bus.rs2_e, bus.rd_e,
                bus.pc_e, bus.pc_plus4_e};

  function automatic logic [10:0] c(bit rw, logic [1:0] rs, bit mw, bit j, bit b,
                                    bit as, logic [2:0] alu, bit ill);
    return {rw, rs, mw, j, b, as, alu, ill};
  endfunction

  function automatic exp_t mk(string nm, logic [31:0] ins, logic [10:0] ct,
                              logic [31:0] imm, bit ichk, logic [31:0] pc);
    exp_t e;
    e.name      = nm;
    e.imm_chk   = ichk;
    e.o.ctrl    = ct;
    e.o.rd1     = regm[ins[19:15]];
    e.o.rd2     = regm[ins[24:20]];
    e.o.imm     = imm;
    e.o.rs1     = ins[19:15];
    e.o.rs2     = ins[24:20];
    e.o.rd      = ins[11:7];
    e.o.pc      = pc;
    e.o.pc4     = pc + 32'd4;
    return e;
  endfunction

  function automatic exp_t zero_exp(string nm);
    exp_t e;
    e.name    = nm;
    e.o       = '0;
    e.imm_chk = 1'b1;
    return e;
  endfunction

  task automatic set_in(logic [31:0] ins, logic [31:0] pc);
    bus.instr_d    = ins;
    bus.pc_d       = pc;
    bus.pc_plus4_d = pc + 32'd4;
  endtask

  // Drive an instruction and queue what E must show after the next edge
  task automatic drive(string nm, logic [31:0] ins, logic [10:0] ct,
                       logic [31:0] imm, bit ichk, logic [31:0] pc);
    set_in(ins, pc);
    sb.push_back(mk(nm, ins, ct, imm, ichk, pc));
  endtask

  // W-port write this cycle; the model sees it immediately (bypass semantics)
  task automatic wport(logic [4:0] r, logic [31:0] v);
    bus.reg_write_w = 1'b1;
    bus.rd_w        = r;
    bus.result_w    = v;
    if (r != 5'd0) regm[r] = v;
  endtask

  task automatic tick();
    obs_t a, x;
    exp_t e;
    @(posedge clk);
    #1;
    bus.reg_write_w = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = act;
      x = e.o;
      if (!e.imm_chk) begin
        a.imm = '0;
        x.imm = '0;
      end
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL %s: got ctrl=%b rd1=%h rd2=%h imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h pc4=%h, want ctrl=%b rd1=%h rd2=%h imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h pc4=%h",
                 e.name, a.ctrl, a.rd1, a.rd2, a.imm, a.rs1, a.rs2, a.rd, a.pc, a.pc4,
                 x.ctrl, x.rd1, x.rd2, x.imm, x.rs1, x.rs2, x.rd, x.pc, x.pc4);
      end
    end
  endtask

  initial begin
    logic [10:0] c_add, c_addi, c_ill;
    exp_t held;
    c_add  = c(1, 2'b00, 0, 0, 0, 0, 3'b000, 0);
    c_addi = c(1, 2'b00, 0, 0, 0, 1, 3'b000, 0);
    c_ill  = c(0, 2'b00, 0, 0, 0, 0, 3'b000, 1);

    tbl[0]  = '{"add x6,x5,x0",  32'h00028333, c_add,                           32'h0,        0};
    tbl[1]  = '{"sub x3,x1,x2",  32'h402081B3, c(1, 2'b00, 0, 0, 0, 0, 3'b001, 0), 32'h0,        0};
    tbl[2]  = '{"and x4,x1,x2",  32'h0020F233, c(1, 2'b00, 0, 0, 0, 0, 3'b010, 0), 32'h0,        0};
    tbl[3]  = '{"or x4,x1,x2",   32'h0020E233, c(1, 2'b00, 0, 0, 0, 0, 3'b011, 0), 32'h0,        0};
    tbl[4]  = '{"slt x4,x1,x2",  32'h0020A233, c(1, 2'b00, 0, 0, 0, 0, 3'b101, 0), 32'h0,        0};
    tbl[5]  = '{"addi x8,x7,-1", 32'hFFF38413, c_addi,                          32'hFFFFFFFF, 1};
    tbl[6]  = '{"lw x9,12(x1)",  32'h00C0A483, c(1, 2'b01, 0, 0, 0, 1, 3'b000, 0), 32'h0000000C, 1};
    tbl[7]  = '{"sw x2,-4(x1)",  32'hFE20AE23, c(0, 2'b00, 1, 0, 0, 1, 3'b000, 0), 32'hFFFFFFFC, 1};
    // beq compares with a subtract
    tbl[8]  = '{"beq x1,x2,-8",  32'hFE208CE3, c(0, 2'b00, 0, 0, 1, 0, 3'b001, 0), 32'hFFFFFFF8, 1};
    tbl[9]  = '{"jal x1,+2048",  32'h001000EF, c(1, 2'b10, 0, 1, 0, 0, 3'b000, 0), 32'h00000800, 1};
    tbl[10] = '{"all ones",      32'hFFFFFFFF, c_ill,                           32'h0,        0};
    tbl[11] = '{"nop addi x0",   32'h00000013, c_addi,                          32'h0,        1};
    tbl[12] = '{"slli illegal",  32'h00109093, c_ill,                           32'h0,        0};
    tbl[13] = '{"R f7=20 and",   32'h4020F233, c_ill,                           32'h0,        0};
    tbl[14] = '{"bne illegal",   32'hFE209CE3, c_ill,                           32'h0,        0};

    for (int i = 0; i < 32; i++) regm[i] = '0;
    rst             = 1'b1;
    bus.stall_e     = 1'b0;
    bus.flush_e     = 1'b0;
    bus.reg_write_w = 1'b0;
    bus.rd_w        = '0;
    bus.result_w    = '0;
    set_in(32'h00000013, 32'h0);

    // reset held two cycles
    tick();
    sb.push_back(zero_exp("reset state"));
    tick();
    rst = 1'b0;

    // every register reads zero after reset: add x0, xi, x(32-i)
    for (int i = 1; i < 32; i++) begin
      logic [4:0] a, b;
      a = 5'(i);
      b = 5'(32 - i);
      drive($sformatf("post-reset read x%0d", i),
            {7'b0, b, a, 3'b000, 5'd0, 7'b0110011}, c_add, 32'h0, 0, 32'h200 + 32'(4 * i));
      tick();
    end

    wport(5'd1, 32'h11111111);  tick();
    wport(5'd2, 32'h22222222);  tick();
    wport(5'd5, 32'hDEADBEEF);  tick();
    wport(5'd31, 32'hF0F0F0F0); tick();

    foreach (tbl[i]) begin
      drive(tbl[i].name, tbl[i].instr, tbl[i].ctrl, tbl[i].imm, tbl[i].imm_chk,
            32'h1000 + 32'(4 * i));
      tick();
    end

    // same-cycle write and read of x7
    wport(5'd7, 32'h00001234);
    drive("bypass addi x8,x7,-1", 32'hFFF38413, c_addi, 32'hFFFFFFFF, 1, 32'h2000);
    tick();

    // x0 write in the same cycle as a read of x0, then a later read
    wport(5'd0, 32'hFFFF0000);
    drive("x0 same-cycle read", 32'h000000B3, c_add, 32'h0, 0, 32'h2004);
    tick();
    drive("x0 later read", 32'h000000B3, c_add, 32'h0, 0, 32'h2008);
    tick();

    // stall holds E for two cycles while instr_d changes; the W write lands
    drive("pre-stall add", 32'h00028333, c_add, 32'h0, 0, 32'h3000);
    tick();
    held = sb.size() == 0 ? mk("stall hold 1", 32'h00028333, c_add, 32'h0, 0, 32'h3000)
                          : sb[0];
    held.name = "stall hold 1";
    bus.stall_e = 1'b1;
    wport(5'd9, 32'hCAFEF00D);
    set_in(32'h402081B3, 32'h3004);
    sb.push_back(held);
    tick();
    held.name = "stall hold 2";
    set_in(32'h001000EF, 32'h3008);
    sb.push_back(held);
    tick();
    bus.stall_e = 1'b0;
    drive("write during stall", 32'h00048533, c_add, 32'h0, 0, 32'h300C);
    tick();

    // flush beats stall; flush alone also bubbles, including illegal_e
    bus.stall_e = 1'b1;
    bus.flush_e = 1'b1;
    set_in(32'hFFFFFFFF, 32'h3010);
    sb.push_back(zero_exp("stall+flush bubble"));
    tick();
    bus.stall_e = 1'b0;
    sb.push_back(zero_exp("flush bubble"));
    tick();
    bus.flush_e = 1'b0;

    // reset mid-stream clears ID/EX and the register file on that edge
    drive("lw before rst", 32'h00C0A483, c(1, 2'b01, 0, 0, 0, 1, 3'b000, 0),
          32'h0000000C, 1, 32'h4000);
    tick();
    rst = 1'b1;
    set_in(32'h00028333, 32'h4004);
    sb.push_back(zero_exp("mid-stream reset"));
    tick();
    for (int i = 0; i < 32; i++) regm[i] = '0;
    rst = 1'b0;
    drive("x5 after reset", 32'h00028333, c_add, 32'h0, 0, 32'h4008);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
